// File: rtl/bcd_decoder_if.sv
// Valid/ready bundle between a BCD source, the decoder and its consumer.
// The decoder takes the slave side; the producer/consumer takes master.
interface bcd_decoder_if #(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
);
  logic [DIGITS*4-1:0] in_bcd;
  logic                in_valid;
  logic                in_ready;
  logic [BIN_W-1:0]    out_bin;
  logic                out_err;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_bcd,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_bin,
    input  out_err,
    input  out_valid
  );

  modport slave (
    input  in_bcd,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_bin,
    output out_err,
    output out_valid
  );
endinterface

// File: rtl/bcd_decoder.sv
// Sequential BCD-to-binary converter, one digit per cycle, MSD first.
// Define BCD_DECODER_CHECK_EN to build the illegal-digit (>9) error flag.
module bcd_decoder #(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic          clk,
  input  logic          rst,
  bcd_decoder_if.slave  bus
);

  localparam int W     = DIGITS * 4;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

  localparam longint unsigned BIN_SPAN = 64'd1 << BIN_W;

  if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
    $error("bcd_decoder: DIGITS must be 1..9");
  end

  if (BIN_W < 4 || BIN_W > 62 || BIN_SPAN < pow10(DIGITS)) begin : g_bad_width
    $error("bcd_decoder: BIN_W too narrow for DIGITS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      sr_q, sr_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [3:0]        digit;
  logic [BIN_W-1:0]  digit_ext;

  assign digit     = sr_q[W-1 -: 4];
  assign digit_ext = {{(BIN_W-4){1'b0}}, digit};

`ifdef BCD_DECODER_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef BCD_DECODER_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr_d    = bus.in_bcd;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef BCD_DECODER_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = CONV;
        end
      end
      CONV: begin
        // acc*10 as shift-add; sums wrap modulo 2**BIN_W
        acc_d = (acc_q << 3) + (acc_q << 1) + digit_ext;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + ONE;
`ifdef BCD_DECODER_CHECK_EN
        err_d = err_q | (digit > 4'd9);
`endif
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BCD_DECODER_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = acc_q;

endmodule

// File: doc/bcd_decoder.md
# bcd_decoder

Sequential BCD-to-binary converter: accepts a packed multi-digit BCD word over a valid/ready handshake, folds it into a binary value one digit per cycle (most significant digit first) and presents the result on a valid/ready output. It is the consuming end of the BCD counter chain: it turns counter or user-entered BCD values back into binary for comparison, arithmetic and register readback.

## Interface
- `DIGITS`, default 6: number of BCD digits in the input word; range 1 to 9.
- `BIN_W`, default 20: binary output width. Must satisfy `2**BIN_W >= 10**DIGITS`; elaboration fails otherwise.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_bcd` in DIGITS*4: packed BCD word; digit i is at `[i*4 +: 4]`; digit 0 is least significant.
- `in_valid` in 1: `in_bcd` is valid.
- `in_ready` out 1: block can accept a word.
- `out_bin` out BIN_W: converted binary value.
- `out_err` out 1: at least one input digit was greater than 9 (see Configuration).
- `out_valid` out 1: `out_bin`/`out_err` are valid.
- `out_ready` in 1: downstream accepts the result.

## Operation
- FSM states: IDLE, CONV, DONE.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid & in_ready`:
    - capture `in_bcd` into the shift register;
    - clear the accumulator (`acc`=0) and digit counter (`cnt`=0);
    - clear the error flag;
    - go to CONV.
- **CONV**
  - Each cycle:
    - `acc <= acc*10 + d`, where `d` is the top digit of the shift register;
    - shift the register left by 4 bits;
    - increment `cnt`.
  - When `cnt` reaches DIGITS-1 on that edge, go to DONE.
- **DONE**
  - `out_valid`=1; `out_bin`=`acc`.
  - On `out_valid & out_ready`, go to IDLE.
- `in_ready` is 0 in CONV and DONE. There is no input skid or overlap.
- Arithmetic:
  - `acc*10` is computed as `(acc<<3)+(acc<<1)`.
  - All sums are truncated modulo `2**BIN_W`.
  - The digit is zero-extended to BIN_W.
- Illegal digits (0xA to 0xF) are folded in by their raw value (e.g. 0xF adds 15). They are never clamped.
- `out_bin` and `out_err` hold stable while `out_valid & !out_ready`.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_bin`=0, `out_err`=0, shift register=0, `cnt`=0.
- Reset during CONV or DONE:
  - the conversion in flight is discarded;
  - no `out_valid` pulse is produced;
  - `in_ready`=1 on the first cycle after the reset edge.
- `in_valid` while not in IDLE is ignored. The source must hold the word, per the handshake rule.

## Timing
- An input transfer occurs on edge E0 (`in_valid & in_ready`).
- Digits are consumed on edges E1 through E_DIGITS.
- `out_valid` rises after edge E_DIGITS. Latency is DIGITS cycles from input acceptance to `out_valid`.
- The output transfer occurs on an edge where `out_valid & out_ready`. `in_ready` rises after that edge.
- Minimum period between accepted words: DIGITS+2 cycles (accept, DIGITS conversion cycles, output handshake).
- All outputs are registered. There is no combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.
- Handshake rules:
  - Once `in_valid` is asserted, the source holds it and `in_bcd` until accepted.
  - `out_valid` never drops without a transfer, except on `rst`.

## Configuration
- Macro: `BCD_DECODER_CHECK_EN`.
- **Defined**
  - Each digit consumed in CONV is compared against 9.
  - A sticky error flag is set if any digit is greater than 9.
  - `out_err` presents the flag alongside `out_valid`.
  - The flag clears on the next input acceptance and on `rst`.
- **Undefined**
  - No comparators are built.
  - `out_err` is tied to 0.
  - Conversion behaviour is otherwise identical.

## Test plan
- All cases use DIGITS=6, BIN_W=20.
- `in_bcd`=0x123456 accepted with `out_ready`=1 -> `out_valid` exactly 6 cycles later, `out_bin`=123456 (0x1E240), `out_err`=0, `in_ready`=1 the cycle after the output transfer.
- `in_bcd`=0x999999, then 0x000000 back-to-back -> `out_bin`=999999 (0xF423F), then 0. Second acceptance occurs 8 cycles after the first.
- With `BCD_DECODER_CHECK_EN`, `in_bcd`=0x00000F -> `out_bin`=15, `out_err`=1. The next word 0x000007 -> `out_bin`=7, `out_err`=0. Without the macro, `out_err`=0 for both.
- `out_ready` held low for 10 cycles in DONE -> `out_valid`=1 and `out_bin` stable; `in_ready`=0 throughout, and `in_valid` is ignored. Releasing `out_ready` completes exactly one transfer.
- Assert `rst` for 1 cycle at the third CONV cycle of 0x654321 -> no `out_valid` pulse; `in_ready`=1 the next cycle; a following 0x000042 yields `out_bin`=42.
- Assert `rst` while in DONE with `out_ready`=0 -> `out_valid`=0, `out_bin`=0, `out_err`=0 after the edge.
